// File: rtl/xed_pkg.sv
// Shared constants and FSM state type for the XED stripe encode sequencer.
package xed_pkg;

  localparam int unsigned NUM_CHIPS = 8;
  localparam int unsigned CHIP_W    = 128;
  localparam int unsigned GROUP_W   = 64;
  localparam int unsigned CRC_W     = 8;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_HOLD    = 3'd4
  } xed_seq_state_t;

endpackage

// File: rtl/xed_stripe_buf.sv
// Stripe register file: one CHIP_W entry per chip, single write port,
// whole stripe presented on a flat read bus.
module xed_stripe_buf #(
  parameter int unsigned NUM_CHIPS = xed_pkg::NUM_CHIPS,
  parameter int unsigned CHIP_W    = xed_pkg::CHIP_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_CHIPS)-1:0]  wr_idx,
  input  logic [CHIP_W-1:0]             wr_data,
  output logic [NUM_CHIPS*CHIP_W-1:0]   rd_bus
);

  logic [CHIP_W-1:0] mem_q [NUM_CHIPS];
  logic [CHIP_W-1:0] mem_d [NUM_CHIPS];

  // Next-state of the register file: overwrite the addressed chip on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  // Storage flops, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CHIPS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Flatten the stripe: chip k occupies [CHIP_W*k +: CHIP_W].
  always_comb begin
    rd_bus = '0;
    for (int unsigned i = 0; i < NUM_CHIPS; i++) begin
      rd_bus[CHIP_W*i +: CHIP_W] = mem_q[i];
    end
  end

endmodule

// File: rtl/xed_encode_sequencer.sv
// Collects one stripe of chip beats, launches the XED encoder, captures its
// CRC/parity results and holds them on a ready/valid output.
module xed_encode_sequencer #(
  parameter int unsigned NUM_CHIPS   = xed_pkg::NUM_CHIPS,
  parameter int unsigned CHIP_W      = xed_pkg::CHIP_W,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned ENC_TIMEOUT = 15
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [CHIP_W-1:0]                   in_data,
  input  logic                                in_last,
  input  logic [TAG_W-1:0]                    in_tag,
  output logic                                enc_data_valid,
  output logic [NUM_CHIPS*CHIP_W-1:0]         enc_chip_bus,
  input  logic                                enc_valid,
  input  logic [NUM_CHIPS*xed_pkg::CRC_W-1:0] enc_chip_crc,
  input  logic [2*xed_pkg::GROUP_W-1:0]       enc_simple_par,
  input  logic [2*xed_pkg::GROUP_W-1:0]       enc_wght_par,
  input  logic [xed_pkg::CRC_W-1:0]           enc_simple_crc,
  input  logic [xed_pkg::CRC_W-1:0]           enc_wght_crc,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_CHIPS*xed_pkg::CRC_W-1:0] out_chip_crc,
  output logic [2*xed_pkg::GROUP_W-1:0]       out_simple_par,
  output logic [2*xed_pkg::GROUP_W-1:0]       out_wght_par,
  output logic [xed_pkg::CRC_W-1:0]           out_simple_crc,
  output logic [xed_pkg::CRC_W-1:0]           out_wght_crc,
  output logic [TAG_W-1:0]                    out_tag,
  output logic                                frame_err,
  output logic                                timeout_err,
  output logic [15:0]                         stripe_cnt
);

  import xed_pkg::*;

  localparam int unsigned BEAT_W = $clog2(NUM_CHIPS);
  localparam int unsigned TMO_W  = $clog2(ENC_TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_CHIPS - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(ENC_TIMEOUT);

  xed_seq_state_t                    state_q, state_d;
  logic [BEAT_W-1:0]                 beat_cnt_q, beat_cnt_d;
  logic [TMO_W-1:0]                  tmo_cnt_q, tmo_cnt_d;
  logic [TAG_W-1:0]                  tag_q, tag_d;
  logic                              in_ready_q, in_ready_d;
  logic                              enc_data_valid_q, enc_data_valid_d;
  logic                              out_valid_q, out_valid_d;
  logic [NUM_CHIPS*CRC_W-1:0]        out_chip_crc_q, out_chip_crc_d;
  logic [2*GROUP_W-1:0]              out_simple_par_q, out_simple_par_d;
  logic [2*GROUP_W-1:0]              out_wght_par_q, out_wght_par_d;
  logic [CRC_W-1:0]                  out_simple_crc_q, out_simple_crc_d;
  logic [CRC_W-1:0]                  out_wght_crc_q, out_wght_crc_d;
  logic [TAG_W-1:0]                  out_tag_q, out_tag_d;
  logic                              frame_err_q, frame_err_d;
  logic                              timeout_err_q, timeout_err_d;
  logic [15:0]                       stripe_cnt_q, stripe_cnt_d;

  logic accept;
  logic buf_wr_en;

  xed_stripe_buf #(
    .NUM_CHIPS (NUM_CHIPS),
    .CHIP_W    (CHIP_W)
  ) u_stripe_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_wr_en),
    .wr_idx  (beat_cnt_q),
    .wr_data (in_data),
    .rd_bus  (enc_chip_bus)
  );

  assign accept = in_valid && in_ready_q;

  // Sequencer next-state: beat collection, encoder launch/wait and result hold.
  always_comb begin
    state_d          = state_q;
    beat_cnt_d       = beat_cnt_q;
    tmo_cnt_d        = tmo_cnt_q;
    tag_d            = tag_q;
    out_chip_crc_d   = out_chip_crc_q;
    out_simple_par_d = out_simple_par_q;
    out_wght_par_d   = out_wght_par_q;
    out_simple_crc_d = out_simple_crc_q;
    out_wght_crc_d   = out_wght_crc_q;
    out_tag_d        = out_tag_q;
    stripe_cnt_d     = stripe_cnt_q;
    frame_err_d      = 1'b0;
    timeout_err_d    = 1'b0;
    buf_wr_en        = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          buf_wr_en = 1'b1;
          if (beat_cnt_q == '0) begin
            tag_d = in_tag;
          end
          if (in_last) begin
            beat_cnt_d = '0;
            if (beat_cnt_q == LAST_BEAT) begin
              state_d = ST_LAUNCH;
            end else begin
              frame_err_d = 1'b1;
            end
          end else if (beat_cnt_q == LAST_BEAT) begin
            frame_err_d = 1'b1;
            beat_cnt_d  = '0;
            state_d     = ST_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (accept && in_last) begin
          state_d = ST_COLLECT;
        end
      end
      ST_LAUNCH: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (enc_valid) begin
          out_chip_crc_d   = enc_chip_crc;
          out_simple_par_d = enc_simple_par;
          out_wght_par_d   = enc_wght_par;
          out_simple_crc_d = enc_simple_crc;
          out_wght_crc_d   = enc_wght_crc;
          out_tag_d        = tag_q;
          state_d          = ST_HOLD;
        end else if (tmo_cnt_q == TMO_MAX) begin
          timeout_err_d = 1'b1;
          state_d       = ST_COLLECT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          stripe_cnt_d = stripe_cnt_q + 16'd1;
          state_d      = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase

    // Handshake strobes are registered from the next state so they line up
    // with the state they belong to without a combinational decode.
    in_ready_d       = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
    enc_data_valid_d = (state_d == ST_LAUNCH);
    out_valid_d      = (state_d == ST_HOLD);
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_COLLECT;
      beat_cnt_q       <= '0;
      tmo_cnt_q        <= '0;
      tag_q            <= '0;
      in_ready_q       <= 1'b0;
      enc_data_valid_q <= 1'b0;
      out_valid_q      <= 1'b0;
      out_chip_crc_q   <= '0;
      out_simple_par_q <= '0;
      out_wght_par_q   <= '0;
      out_simple_crc_q <= '0;
      out_wght_crc_q   <= '0;
      out_tag_q        <= '0;
      frame_err_q      <= 1'b0;
      timeout_err_q    <= 1'b0;
      stripe_cnt_q     <= '0;
    end else begin
      state_q          <= state_d;
      beat_cnt_q       <= beat_cnt_d;
      tmo_cnt_q        <= tmo_cnt_d;
      tag_q            <= tag_d;
      in_ready_q       <= in_ready_d;
      enc_data_valid_q <= enc_data_valid_d;
      out_valid_q      <= out_valid_d;
      out_chip_crc_q   <= out_chip_crc_d;
      out_simple_par_q <= out_simple_par_d;
      out_wght_par_q   <= out_wght_par_d;
      out_simple_crc_q <= out_simple_crc_d;
      out_wght_crc_q   <= out_wght_crc_d;
      out_tag_q        <= out_tag_d;
      frame_err_q      <= frame_err_d;
      timeout_err_q    <= timeout_err_d;
      stripe_cnt_q     <= stripe_cnt_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign enc_data_valid = enc_data_valid_q;
  assign out_valid      = out_valid_q;
  assign out_chip_crc   = out_chip_crc_q;
  assign out_simple_par = out_simple_par_q;
  assign out_wght_par   = out_wght_par_q;
  assign out_simple_crc = out_simple_crc_q;
  assign out_wght_crc   = out_wght_crc_q;
  assign out_tag        = out_tag_q;
  assign frame_err      = frame_err_q;
  assign timeout_err    = timeout_err_q;
  assign stripe_cnt     = stripe_cnt_q;

endmodule
